// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int          StallBus    = 6;
  localparam logic        Stop        = 1'b1;
  localparam logic        NoStop      = 1'b0;
  localparam int          IF_TO_ID_WD = 33;
  localparam int          BR_WD       = 33;
  localparam logic [31:0] RESET_PC_V  = 32'hBFC0_0000;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [31:0] pc_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_hold_buf.sv
// One-entry instruction hold buffer: keeps the word ID was looking at
// when ID stalls, so a changing SRAM read port cannot corrupt it.
module inst_hold_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] inst_o
);

  logic        hold_v_q;
  logic        hold_v_d;
  logic [31:0] hold_inst_q;
  logic [31:0] hold_inst_d;

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_inst_d = hold_inst_q;
    if (stall_id_i == Stop) begin
      // Capture only on the first stalled cycle; later cycles keep the word.
      if (!hold_v_q) begin
        hold_inst_d = rdata_i;
        hold_v_d    = 1'b1;
      end
    end else begin
      hold_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q    <= 1'b0;
      hold_inst_q <= 32'd0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  assign inst_o = hold_v_q ? hold_inst_q : rdata_i;

endmodule

// File: rtl/if_fetch.sv
// MIPS IF stage: PC register, instruction SRAM drive, pending-redirect
// capture across PC stalls and the stall-safe instruction word for ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_V
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [StallBus-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [31:0]            id_inst
);

  localparam logic [1:0] FSM_BOOT = 2'd0;
  localparam logic [1:0] FSM_RUN  = 2'd1;
  localparam logic [1:0] FSM_HOLD = 2'd2;

  br_bus_t     br;
  logic [1:0]  fsm_q;
  logic [1:0]  fsm_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pend_v_q;
  logic        pend_v_d;
  logic [31:0] pend_addr_q;
  logic [31:0] pend_addr_d;
  logic [31:0] next_pc;
  logic        ce;
  logic        unused_stall;

  assign br           = br_bus;
  assign unused_stall = ^stall[StallBus-1:2];

  // ce is low only until the first unstalled fetch, which is exactly BOOT.
  assign ce = (fsm_q != FSM_BOOT);

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_BOOT: if (stall[0] == NoStop) fsm_d = FSM_RUN;
      FSM_RUN:  if (stall[1] == Stop)   fsm_d = FSM_HOLD;
      FSM_HOLD: if (stall[1] == NoStop) fsm_d = FSM_RUN;
      default:  fsm_d = FSM_BOOT;
    endcase
  end

  always_comb begin
    if (br.br_e)       next_pc = br.br_addr;
    else if (pend_v_q) next_pc = pend_addr_q;
    else               next_pc = pc_seq(pc_q);
  end

  always_comb begin
    pc_d        = pc_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    if (stall[0] == NoStop) begin
      pc_d     = next_pc;
      pend_v_d = 1'b0;
    end else if (br.br_e) begin
      // A redirect arriving while PC is frozen must survive the stall.
      pend_v_d    = 1'b1;
      pend_addr_d = br.br_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= FSM_BOOT;
      pc_q     <= RESET_PC - 32'd4;
      pend_v_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      pc_q     <= pc_d;
      pend_v_q <= pend_v_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
  end

  inst_hold_buf u_hold (
    .clk        (clk),
    .rst        (rst),
    .stall_id_i (stall[1]),
    .rdata_i    (inst_sram_rdata),
    .inst_o     (id_inst)
  );

  assign inst_sram_en    = ~rst & (stall[0] == NoStop);
  assign inst_sram_addr  = next_pc;
  assign inst_sram_wen   = 4'd0;
  assign inst_sram_wdata = 32'd0;
  assign if_to_id_bus    = {ce, pc_q};

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pending redirect and hold buffer as 0/1-entry queues.
  logic        m_ce;
  logic [31:0] m_pc;
  logic [31:0] pendq[$];
  logic [31:0] holdq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_fetch();
    if (br_bus[32]) return br_bus[31:0];
    if (pendq.size() != 0) return pendq[0];
    return m_pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_id();
    return (holdq.size() != 0) ? holdq[0] : inst_sram_rdata;
  endfunction

  task automatic drive(input logic r, input logic [5:0] s, input logic be,
                       input logic [31:0] ba, input logic [31:0] rd);
    rst = r; stall = s; br_bus = {be, ba}; inst_sram_rdata = rd;
    #4;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".bus"}, 64'(if_to_id_bus), 64'({m_ce, m_pc}));
    chk({tag, ".en"},  64'(inst_sram_en), 64'(!rst && !stall[0]));
    if (!rst) chk({tag, ".addr"}, 64'(inst_sram_addr), 64'(m_fetch()));
    chk({tag, ".id"},  64'(id_inst), 64'(m_id()));
  endtask

  task automatic tick();
    logic [31:0] nf;
    @(posedge clk);
    nf = m_fetch();
    if (rst) begin
      m_ce = 1'b0; m_pc = 32'hBFBF_FFFC;
      pendq.delete(); holdq.delete();
    end else begin
      if (!stall[0]) begin
        m_pc = nf; m_ce = 1'b1; pendq.delete();
      end else if (br_bus[32]) begin
        pendq.delete(); pendq.push_back(br_bus[31:0]);
      end
      if (stall[1]) begin
        if (holdq.size() == 0) holdq.push_back(inst_sram_rdata);
      end else begin
        holdq.delete();
      end
    end
    #1;
  endtask

  task automatic cyc(input string tag, input logic r, input logic [5:0] s,
                     input logic be, input logic [31:0] ba, input logic [31:0] rd);
    drive(r, s, be, ba, rd);
    check_model(tag);
  endtask

  typedef struct {
    logic        r;
    logic [5:0]  s;
    logic        be;
    logic [31:0] ba;
    logic [31:0] rd;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_ce;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1'b1, 6'd0, 1'b0, 32'h0,          32'h1111_0000, 1'b0, 32'h0,          1'b0, 32'hBFBF_FFFC};
    vt[1] = '{1'b0, 6'd0, 1'b0, 32'h0,          32'h1111_0001, 1'b1, 32'hBFC0_0000, 1'b0, 32'hBFBF_FFFC};
    vt[2] = '{1'b0, 6'd0, 1'b0, 32'h0,          32'h1111_0002, 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0000};
    vt[3] = '{1'b0, 6'd0, 1'b0, 32'h0,          32'h1111_0003, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0004};
    vt[4] = '{1'b0, 6'd0, 1'b0, 32'h0,          32'h1111_0004, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0008};
    vt[5] = '{1'b0, 6'd0, 1'b1, 32'hBFC0_0100, 32'h1111_0005, 1'b1, 32'hBFC0_0100, 1'b1, 32'hBFC0_000C};
    vt[6] = '{1'b0, 6'd0, 1'b0, 32'h0,          32'h1111_0006, 1'b1, 32'hBFC0_0104, 1'b1, 32'hBFC0_0100};

    drive(1'b1, 6'd0, 1'b0, 32'h0, 32'h0);
    tick();

    for (int i = 0; i < 7; i++) begin
      drive(vt[i].r, vt[i].s, vt[i].be, vt[i].ba, vt[i].rd);
      chk($sformatf("tbl%0d.en", i), 64'(inst_sram_en), 64'(vt[i].e_en));
      if (!vt[i].r) chk($sformatf("tbl%0d.addr", i), 64'(inst_sram_addr), 64'(vt[i].e_addr));
      chk($sformatf("tbl%0d.bus", i), 64'(if_to_id_bus), 64'({vt[i].e_ce, vt[i].e_pc}));
      chk($sformatf("tbl%0d.id", i), 64'(id_inst), 64'(vt[i].rd));
      tick();
    end
    chk("wen", 64'(inst_sram_wen), 64'd0);
    chk("wdata", 64'(inst_sram_wdata), 64'd0);

    // PC stall with a redirect in the middle of it.
    for (int i = 0; i < 3; i++) begin
      cyc("pstall", 1'b0, 6'b000001, i == 1, 32'hBFC0_0200, 32'h0);
      chk("pstall.en", 64'(inst_sram_en), 64'd0);
      chk("pstall.pc", 64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0104}));
      tick();
    end
    cyc("prel", 1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
    chk("prel.addr", 64'(inst_sram_addr), 64'(32'hBFC0_0200));
    tick();
    cyc("prel2", 1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
    chk("prel2.addr", 64'(inst_sram_addr), 64'(32'hBFC0_0204));
    chk("prel2.pc", 64'(if_to_id_bus[31:0]), 64'(32'hBFC0_0200));
    tick();

    // ID stall: the captured word must survive rdata changing underneath.
    for (int i = 0; i < 4; i++) begin
      cyc("hold", 1'b0, 6'b000010, 1'b0, 32'h0, (i == 0) ? 32'h1111_1111 : 32'hDEAD_BEEF);
      chk("hold.id", 64'(id_inst), 64'(32'h1111_1111));
      tick();
    end
    cyc("hrel", 1'b0, 6'd0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    tick();
    cyc("hfollow", 1'b0, 6'd0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("hfollow.id", 64'(id_inst), 64'(32'hDEAD_BEEF));
    tick();
    cyc("hb2b0", 1'b0, 6'b000010, 1'b0, 32'h0, 32'h2222_2222);
    tick();
    cyc("hb2b1", 1'b0, 6'd0, 1'b0, 32'h0, 32'h3333_3333);
    tick();
    cyc("hb2b2", 1'b0, 6'b000010, 1'b0, 32'h0, 32'h4444_4444);
    tick();
    cyc("hb2b3", 1'b0, 6'b000010, 1'b0, 32'h0, 32'h5555_5555);
    chk("hb2b3.id", 64'(id_inst), 64'(32'h4444_4444));
    tick();

    // Pending redirect loses to a live branch on the release cycle.
    cyc("pend", 1'b0, 6'b000001, 1'b1, 32'hBFC0_0300, 32'h0);
    tick();
    cyc("live", 1'b0, 6'd0, 1'b1, 32'hBFC0_0400, 32'h0);
    chk("live.addr", 64'(inst_sram_addr), 64'(32'hBFC0_0400));
    tick();
    cyc("live2", 1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
    chk("live2.addr", 64'(inst_sram_addr), 64'(32'hBFC0_0404));
    tick();

    // 32-bit PC wrap.
    cyc("wrap0", 1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    tick();
    cyc("wrap1", 1'b0, 6'd0, 1'b0, 32'h0, 32'h0);
    chk("wrap.addr", 64'(inst_sram_addr), 64'd0);
    tick();

    // Reset while both the pending redirect and hold buffer are live.
    cyc("rs0", 1'b0, 6'b000011, 1'b1, 32'hBFC0_0500, 32'hAAAA_AAAA);
    tick();
    cyc("rs1", 1'b1, 6'b000011, 1'b0, 32'h0, 32'hBBBB_BBBB);
    tick();
    cyc("rs2", 1'b0, 6'd0, 1'b0, 32'h0, 32'h5555_0000);
    chk("rs2.bus", 64'(if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
    chk("rs2.addr", 64'(inst_sram_addr), 64'(32'hBFC0_0000));
    chk("rs2.id", 64'(id_inst), 64'(32'h5555_0000));
    tick();

    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [5:0] s;
      logic       be;
      r  = ($urandom_range(0, 39) == 0);
      s  = 6'($urandom);
      s[0] = ($urandom_range(0, 3) == 0);
      s[1] = ($urandom_range(0, 2) == 0);
      be = ($urandom_range(0, 5) == 0);
      cyc("rnd", r, s, be, {$urandom} & 32'hFFFF_FFFC, $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
